wb_master_burst: RTL and testbench

Parametrised Wishbone B3 master bridging the CPU pipeline's memory-request port to the Wishbone bus. Successor of the single-beat bus interface: adds configurable address/data width, incrementing read bursts with cycle-type tags, retry handling with bounded back-off, and a bus-timeout error. Instantiated once per CPU port (instruction fetch and data access), between the pipeline stage and the bus interconnect, and drives the pipeline `stallreq` to CTRL.

---
 rtl/wb_master_burst.sv | 266 ++++++++++++++++++++++++++
 tb/tb_wb_master_burst.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_burst.sv
// Wishbone B3 master for one CPU memory port. It supports single-beat writes,
// incrementing read bursts tagged through CTI, bounded retry with a one-cycle
// back-off, and a bus-timeout error. It drives the pipeline stall request.
module wb_master_burst #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BEATS = 8,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned RETRY_MAX = 3,
    localparam int unsigned SW = DW / 8,
    localparam int unsigned LW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    stall_i,
    input  logic          flush_i,
    input  logic          cpu_ce_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_data_i,
    input  logic          cpu_we_i,
    input  logic [SW-1:0] cpu_sel_i,
    input  logic [LW-1:0] cpu_len_i,
    output logic [DW-1:0] cpu_data_o,
    output logic          cpu_rvalid_o,
    output logic          cpu_err_o,
    output logic          stallreq,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_we_o,
    output logic [SW-1:0] wb_sel_o,
    output logic          wb_stb_o,
    output logic          wb_cyc_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    // The timeout fires in the BUSY cycle where the count would reach TIMEOUT.
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    localparam logic [AW-1:0] ADR_STEP  = AW'(SW);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_BACKOFF,
        S_WAIT_FOR_STALL
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] adr_q,   adr_d;
    logic [DW-1:0] dat_q,   dat_d;
    logic          we_q,    we_d;
    logic [SW-1:0] sel_q,   sel_d;
    logic          stb_q,   stb_d;
    logic          cyc_q,   cyc_d;
    logic [2:0]    cti_q,   cti_d;
    logic [LW-1:0] beats_q, beats_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q,   tmo_d;
    logic [DW-1:0] rbuf_q,  rbuf_d;
    logic          err_q,   err_d;

    logic          stall_c;
    logic          rvalid_c;
    logic [DW-1:0] rdata_c;
    logic          rel_c;
    logic          fail_c;
    logic          abort_c;
    logic          last_beat;

    // Next-state and combinational outputs. The BUSY arm only raises flags for
    // release/error/abort; their register effects are applied once after the case.
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        we_d     = we_q;
        sel_d    = sel_q;
        stb_d    = stb_q;
        cyc_d    = cyc_q;
        cti_d    = cti_q;
        beats_d  = beats_q;
        retry_d  = retry_q;
        tmo_d    = tmo_q;
        rbuf_d   = rbuf_q;
        err_d    = err_q;
        stall_c  = 1'b0;
        rvalid_c = 1'b0;
        rdata_c  = '0;
        rel_c    = 1'b0;
        fail_c   = 1'b0;
        abort_c  = 1'b0;
        last_beat = (beats_q == '0);

        unique case (state_q)
            S_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    stall_c = 1'b1;
                    adr_d   = cpu_addr_i;
                    dat_d   = cpu_data_i;
                    we_d    = cpu_we_i;
                    sel_d   = cpu_sel_i;
                    beats_d = cpu_we_i ? '0 : cpu_len_i;
                    cti_d   = (cpu_we_i || (cpu_len_i == '0)) ? CTI_CLASSIC : CTI_INCR;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    err_d   = 1'b0;
                    retry_d = '0;
                    tmo_d   = '0;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                stall_c = 1'b1;
                if (wb_ack_i) begin
                    if (!we_q) begin
                        rvalid_c = 1'b1;
                        rdata_c  = wb_dat_i;
                    end
                    if (last_beat) begin
                        stall_c = 1'b0;
                        rel_c   = 1'b1;
                        rbuf_d  = we_q ? '0 : wb_dat_i;
                        state_d = (stall_i != '0) ? S_WAIT_FOR_STALL : S_IDLE;
                    end else if (flush_i) begin
                        abort_c = 1'b1;
                    end else begin
                        adr_d   = adr_q + ADR_STEP;
                        beats_d = beats_q - LW'(1);
                        retry_d = '0;
                        tmo_d   = '0;
                        cti_d   = (beats_q == LW'(1)) ? CTI_END : CTI_INCR;
                    end
                end else if (wb_err_i) begin
                    fail_c = 1'b1;
                end else if (wb_rty_i) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + RW'(1);
                        tmo_d   = '0;
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        state_d = S_BACKOFF;
                    end else begin
                        fail_c = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    fail_c = 1'b1;
                end else if (flush_i) begin
                    abort_c = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_BACKOFF: begin
                stall_c = 1'b1;
                if (flush_i) begin
                    rel_c   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = S_BUSY;
                end
            end

            S_WAIT_FOR_STALL: begin
                rdata_c = rbuf_q;
                if (stall_i == '0) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fail_c) begin
            stall_c = 1'b0;
            err_d   = 1'b1;
            rel_c   = 1'b1;
            rbuf_d  = '0;
            state_d = (stall_i != '0) ? S_WAIT_FOR_STALL : S_IDLE;
        end

        if (abort_c) begin
            rel_c   = 1'b1;
            rbuf_d  = '0;
            state_d = S_IDLE;
        end

        if (rel_c) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            adr_d   = '0;
            dat_d   = '0;
            we_d    = 1'b0;
            sel_d   = '0;
            cti_d   = CTI_CLASSIC;
            beats_d = '0;
            retry_d = '0;
            tmo_d   = '0;
        end
    end

    // State and bus-output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            cti_q   <= CTI_CLASSIC;
            beats_q <= '0;
            retry_q <= '0;
            tmo_q   <= '0;
            rbuf_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            cyc_q   <= cyc_d;
            cti_q   <= cti_d;
            beats_q <= beats_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
            rbuf_q  <= rbuf_d;
            err_q   <= err_d;
        end
    end

    assign stallreq     = rst & stall_c;
    assign cpu_rvalid_o = rst & rvalid_c;
    assign cpu_data_o   = rst ? rdata_c : '0;
    assign cpu_err_o    = err_q;

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = sel_q;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = cyc_q;
    assign wb_cti_o = cti_q;
    assign wb_bte_o = 2'b00;

endmodule

// File: tb/tb_wb_master_burst.sv
// Self-checking bench for wb_master_burst. Read data expected on cpu_data_o
// is queued when the slave response is driven and checked by a monitor.
module tb_wb_master_burst;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned LW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [5:0]    stall;
    logic          flush, ce, we, ack, berr, rty;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, wb_din;
    logic [SW-1:0] sel;
    logic [LW-1:0] len;

    logic [DW-1:0] cpu_data, wb_dout;
    logic          rvalid, cpu_err, stallreq, wb_we, wb_stb, wb_cyc;
    logic [AW-1:0] wb_adr;
    logic [SW-1:0] wb_sel;
    logic [2:0]    wb_cti;
    logic [1:0]    wb_bte;

    logic [DW-1:0] r1_cpu_data, r1_wb_dout;
    logic          r1_rvalid, r1_cpu_err, r1_stallreq, r1_wb_we, r1_wb_stb, r1_wb_cyc;
    logic [AW-1:0] r1_wb_adr;
    logic [SW-1:0] r1_wb_sel;
    logic [2:0]    r1_wb_cti;
    logic [1:0]    r1_wb_bte;

    int unsigned   errors = 0;
    int unsigned   checks = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;

    wb_master_burst #(.AW(AW), .DW(DW), .MAX_BEATS(8), .TIMEOUT(16), .RETRY_MAX(3)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .cpu_ce_i(ce),
        .cpu_addr_i(addr), .cpu_data_i(wdata), .cpu_we_i(we), .cpu_sel_i(sel), .cpu_len_i(len),
        .cpu_data_o(cpu_data), .cpu_rvalid_o(rvalid), .cpu_err_o(cpu_err), .stallreq(stallreq),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dout), .wb_we_o(wb_we), .wb_sel_o(wb_sel),
        .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc), .wb_cti_o(wb_cti), .wb_bte_o(wb_bte),
        .wb_dat_i(wb_din), .wb_ack_i(ack), .wb_err_i(berr), .wb_rty_i(rty)
    );

    wb_master_burst #(.AW(AW), .DW(DW), .MAX_BEATS(8), .TIMEOUT(16), .RETRY_MAX(1)) dut_r1 (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .cpu_ce_i(ce),
        .cpu_addr_i(addr), .cpu_data_i(wdata), .cpu_we_i(we), .cpu_sel_i(sel), .cpu_len_i(len),
        .cpu_data_o(r1_cpu_data), .cpu_rvalid_o(r1_rvalid), .cpu_err_o(r1_cpu_err), .stallreq(r1_stallreq),
        .wb_adr_o(r1_wb_adr), .wb_dat_o(r1_wb_dout), .wb_we_o(r1_wb_we), .wb_sel_o(r1_wb_sel),
        .wb_stb_o(r1_wb_stb), .wb_cyc_o(r1_wb_cyc), .wb_cti_o(r1_wb_cti), .wb_bte_o(r1_wb_bte),
        .wb_dat_i(wb_din), .wb_ack_i(ack), .wb_err_i(berr), .wb_rty_i(rty)
    );

    // Read-data scoreboard: every rvalid pulse must match the oldest queued word.
    always @(negedge clk) begin
        #2;
        if (rvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL rvalid_unexpected got=%h exp=none", cpu_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (cpu_data !== mon_exp) begin errors++; $display("FAIL rdata got=%h exp=%h", cpu_data, mon_exp); end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle_inputs();
        stall = '0; flush = 0; ce = 0; we = 0; ack = 0; berr = 0; rty = 0;
        addr = '0; wdata = '0; wb_din = '0; sel = 4'hF; len = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk); idle_inputs(); rst = 0;
        @(negedge clk); rst = 1;
    endtask

    task automatic test_reset();
        @(negedge clk); ce = 1; addr = 32'h100; ack = 1; wb_din = 32'h5555AAAA; #1;
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL rst_stallreq got=%b exp=0", stallreq); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b exp=0", rvalid); end
        checks++; if (cpu_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", cpu_data); end
        @(negedge clk); #1;
        checks++; if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin errors++; $display("FAIL rst_ctl got=%b exp=000", {wb_cyc, wb_stb, wb_we}); end
        checks++; if ({wb_adr, wb_dout} !== 64'h0) begin errors++; $display("FAIL rst_adr_dat got=%h exp=0", {wb_adr, wb_dout}); end
        checks++; if ({wb_sel, wb_cti, wb_bte} !== 9'h0) begin errors++; $display("FAIL rst_sel_cti got=%h exp=0", {wb_sel, wb_cti, wb_bte}); end
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", cpu_err); end
        idle_inputs(); rst = 1;
    endtask

    task automatic test_single_read();
        int hi = 0;
        @(negedge clk); ce = 1; we = 0; addr = 32'h100; len = 0; #1;
        if (stallreq === 1'b1) hi++;
        checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL single_pre_cyc got=%b exp=0", wb_cyc); end
        @(negedge clk); ce = 0; #1;
        if (stallreq === 1'b1) hi++;
        checks++; if ({wb_cyc, wb_stb, wb_we} !== 3'b110) begin errors++; $display("FAIL single_ctl got=%b exp=110", {wb_cyc, wb_stb, wb_we}); end
        checks++; if (wb_adr !== 32'h100) begin errors++; $display("FAIL single_adr got=%h exp=100", wb_adr); end
        checks++; if (wb_cti !== 3'b000) begin errors++; $display("FAIL single_cti got=%b exp=000", wb_cti); end
        @(negedge clk); #1;
        if (stallreq === 1'b1) hi++;
        @(negedge clk); ack = 1; wb_din = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF); #1;
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL single_ack_stall got=%b exp=0", stallreq); end
        checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid got=%b exp=1", rvalid); end
        @(negedge clk); ack = 0; #1;
        checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL single_post_cyc got=%b exp=0", wb_cyc); end
        checks++; if (hi != 3) begin errors++; $display("FAIL single_stall_cycles got=%0d exp=3", hi); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_burst();
        logic [AW-1:0] ea;
        logic [2:0]    ec;
        @(negedge clk); ce = 1; we = 0; addr = 32'h200; len = 3; #1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk); ce = 0; ack = 1; wb_din = 32'hA0000000 + 32'(b); exp_q.push_back(wb_din); #1;
            ea = 32'h200 + 32'(4 * b);
            ec = (b == 3) ? 3'b111 : 3'b010;
            checks++; if (wb_adr !== ea) begin errors++; $display("FAIL burst_adr%0d got=%h exp=%h", b, wb_adr, ea); end
            checks++; if (wb_cti !== ec) begin errors++; $display("FAIL burst_cti%0d got=%b exp=%b", b, wb_cti, ec); end
            checks++; if ({wb_cyc, wb_stb} !== 2'b11) begin errors++; $display("FAIL burst_stb%0d got=%b exp=11", b, {wb_cyc, wb_stb}); end
            checks++; if (stallreq !== (b != 3)) begin errors++; $display("FAIL burst_stall%0d got=%b exp=%b", b, stallreq, b != 3); end
        end
        @(negedge clk); ack = 0; #1;
        checks++; if ({wb_cyc, wb_stb} !== 2'b00) begin errors++; $display("FAIL burst_end_cyc got=%b exp=00", {wb_cyc, wb_stb}); end
        checks++; if (wb_adr !== 32'h0) begin errors++; $display("FAIL burst_end_adr got=%h exp=0", wb_adr); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL burst_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_retry();
        @(negedge clk); ce = 1; we = 1; addr = 32'h300; wdata = 32'hCAFEF00D; sel = 4'b0011; #1;
        @(negedge clk); ce = 0; rty = 1; #1;
        checks++; if ({wb_cyc, wb_we, wb_sel} !== 6'b110011) begin errors++; $display("FAIL retry_ctl got=%b exp=110011", {wb_cyc, wb_we, wb_sel}); end
        checks++; if (wb_dout !== 32'hCAFEF00D) begin errors++; $display("FAIL retry_dat got=%h exp=cafef00d", wb_dout); end
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL retry_stall1 got=%b exp=1", stallreq); end
        @(negedge clk); rty = 0; #1;
        checks++; if ({wb_cyc, wb_stb} !== 2'b00) begin errors++; $display("FAIL retry_bk1_cyc got=%b exp=00", {wb_cyc, wb_stb}); end
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL retry_bk1_stall got=%b exp=1", stallreq); end
        @(negedge clk); rty = 1; #1;
        checks++; if ({wb_cyc, wb_adr} !== {1'b1, 32'h300}) begin errors++; $display("FAIL retry_reissue2 got=%b/%h exp=1/300", wb_cyc, wb_adr); end
        checks++; if (r1_stallreq !== 1'b0) begin errors++; $display("FAIL retry_r1_term_stall got=%b exp=0", r1_stallreq); end
        @(negedge clk); rty = 0; #1;
        checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL retry_bk2_cyc got=%b exp=0", wb_cyc); end
        checks++; if ({r1_cpu_err, r1_wb_cyc} !== 2'b10) begin errors++; $display("FAIL retry_r1_err got=%b exp=10", {r1_cpu_err, r1_wb_cyc}); end
        @(negedge clk); ack = 1; #1;
        checks++; if ({wb_cyc, wb_adr} !== {1'b1, 32'h300}) begin errors++; $display("FAIL retry_reissue3 got=%b/%h exp=1/300", wb_cyc, wb_adr); end
        checks++; if ({stallreq, rvalid} !== 2'b00) begin errors++; $display("FAIL retry_ack got=%b exp=00", {stallreq, rvalid}); end
        @(negedge clk); ack = 0; #1;
        checks++; if ({wb_cyc, cpu_err} !== 2'b00) begin errors++; $display("FAIL retry_done got=%b exp=00", {wb_cyc, cpu_err}); end
        checks++; if (r1_cpu_err !== 1'b1) begin errors++; $display("FAIL retry_r1_err_hold got=%b exp=1", r1_cpu_err); end
        we = 0; sel = 4'hF;
    endtask

    task automatic test_timeout();
        @(negedge clk); ce = 1; we = 0; addr = 32'h400; len = 0; #1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk); ce = 0; #1;
            checks++; if (wb_cyc !== 1'b1) begin errors++; $display("FAIL tmo_cyc%0d got=%b exp=1", k, wb_cyc); end
            checks++; if (stallreq !== (k < 16)) begin errors++; $display("FAIL tmo_stall%0d got=%b exp=%b", k, stallreq, k < 16); end
            if (k == 15) begin
                checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL tmo_early_err got=%b exp=0", cpu_err); end
            end
        end
        @(negedge clk); #1;
        checks++; if ({wb_cyc, cpu_err, stallreq} !== 3'b010) begin errors++; $display("FAIL tmo_end got=%b exp=010", {wb_cyc, cpu_err, stallreq}); end
    endtask

    task automatic test_flush();
        @(negedge clk); ce = 1; we = 0; addr = 32'h500; len = 3; #1;
        @(negedge clk); ce = 0; ack = 1; wb_din = 32'hB0B0B0B0; exp_q.push_back(wb_din); #1;
        @(negedge clk); flush = 1; wb_din = 32'hB1B1B1B1; exp_q.push_back(wb_din); #1;
        checks++; if ({rvalid, wb_adr} !== {1'b1, 32'h504}) begin errors++; $display("FAIL flush_beat2 got=%b/%h exp=1/504", rvalid, wb_adr); end
        @(negedge clk); flush = 0; wb_din = 32'hB2B2B2B2; #1;
        checks++; if ({wb_cyc, wb_stb, wb_cti} !== 5'b0) begin errors++; $display("FAIL flush_release got=%b exp=00000", {wb_cyc, wb_stb, wb_cti}); end
        checks++; if (wb_adr !== 32'h0) begin errors++; $display("FAIL flush_adr got=%h exp=0", wb_adr); end
        checks++; if ({rvalid, stallreq, cpu_err} !== 3'b000) begin errors++; $display("FAIL flush_idle got=%b exp=000", {rvalid, stallreq, cpu_err}); end
        @(negedge clk); ack = 0; #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL flush_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk); ce = 1; we = 0; addr = 32'h600; len = 3; #1;
        @(negedge clk); ce = 0; ack = 1; wb_din = 32'hC0C0C0C0; exp_q.push_back(wb_din); #1;
        @(negedge clk); rst = 0; wb_din = 32'hC1C1C1C1; #1;
        checks++; if ({rvalid, stallreq} !== 2'b00) begin errors++; $display("FAIL rstmid_comb got=%b exp=00", {rvalid, stallreq}); end
        checks++; if (cpu_data !== 32'h0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", cpu_data); end
        @(negedge clk); rst = 1; ack = 0; #1;
        checks++; if ({wb_cyc, wb_stb, wb_we, wb_cti, wb_sel} !== 10'h0) begin errors++; $display("FAIL rstmid_ctl got=%b exp=0", {wb_cyc, wb_stb, wb_we, wb_cti, wb_sel}); end
        checks++; if ({wb_adr, wb_dout} !== 64'h0) begin errors++; $display("FAIL rstmid_adr got=%h exp=0", {wb_adr, wb_dout}); end
        checks++; if ({cpu_err, stallreq} !== 2'b00) begin errors++; $display("FAIL rstmid_err got=%b exp=00", {cpu_err, stallreq}); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_wait_for_stall();
        @(negedge clk); ce = 1; we = 0; addr = 32'h700; len = 0; #1;
        @(negedge clk); ce = 0; ack = 1; wb_din = 32'h12345678; stall = 6'b000011; exp_q.push_back(wb_din); #1;
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL wfs_ack_stall got=%b exp=0", stallreq); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); ack = 0; wb_din = 32'h0; #1;
            checks++; if (cpu_data !== 32'h12345678) begin errors++; $display("FAIL wfs_data%0d got=%h exp=12345678", i, cpu_data); end
            checks++; if ({stallreq, wb_cyc, rvalid} !== 3'b000) begin errors++; $display("FAIL wfs_ctl%0d got=%b exp=000", i, {stallreq, wb_cyc, rvalid}); end
        end
        @(negedge clk); stall = '0; #1;
        checks++; if (cpu_data !== 32'h12345678) begin errors++; $display("FAIL wfs_release_data got=%h exp=12345678", cpu_data); end
        @(negedge clk); ce = 1; addr = 32'h704; #1;
        checks++; if ({cpu_data, stallreq} !== {32'h0, 1'b1}) begin errors++; $display("FAIL wfs_idle got=%h/%b exp=0/1", cpu_data, stallreq); end
        @(negedge clk); ce = 0; ack = 1; wb_din = 32'h9ABCDEF0; exp_q.push_back(wb_din); #1;
        @(negedge clk); ack = 0; #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wfs_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); ce = 1; we = 0; addr = 32'h800; len = 0; #1;
        @(negedge clk); ce = 0; ack = 1; wb_din = 32'h11111111; exp_q.push_back(wb_din); #1;
        checks++; if ({wb_adr, rvalid} !== {32'h800, 1'b1}) begin errors++; $display("FAIL b2b_first got=%h/%b exp=800/1", wb_adr, rvalid); end
        @(negedge clk); ack = 0; ce = 1; addr = 32'h804; #1;
        checks++; if ({wb_cyc, stallreq} !== 2'b01) begin errors++; $display("FAIL b2b_accept got=%b exp=01", {wb_cyc, stallreq}); end
        @(negedge clk); ce = 0; ack = 1; wb_din = 32'h22222222; exp_q.push_back(wb_din); #1;
        checks++; if ({wb_adr, wb_cti} !== {32'h804, 3'b000}) begin errors++; $display("FAIL b2b_second got=%h/%b exp=804/000", wb_adr, wb_cti); end
        @(negedge clk); ack = 0; #1;
        checks++; if ({wb_cyc, exp_q.size() == 0} !== 2'b01) begin errors++; $display("FAIL b2b_done got=%b exp=01", {wb_cyc, exp_q.size() == 0}); end
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        test_reset();
        apply_reset(); test_single_read();
        apply_reset(); test_burst();
        apply_reset(); test_retry();
        apply_reset(); test_timeout();
        apply_reset(); test_flush();
        apply_reset(); test_reset_mid_burst();
        apply_reset(); test_wait_for_stall();
        apply_reset(); test_back_to_back();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
